// File: rtl/timer_counter_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// timer_counter_if: peripheral-bus port bundle for timer_counter (addr/WE/Din in, Dout/IRQ out).
// Rev 1.0
// -----------------------------------------------------------------------------
interface timer_counter_if;
  logic [1:0]  addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  modport master (
    output addr,
    output WE,
    output Din,
    input  Dout,
    input  IRQ
  );

  modport slave (
    input  addr,
    input  WE,
    input  Din,
    output Dout,
    output IRQ
  );
endinterface
`default_nettype wire

// File: rtl/timer_counter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// timer_counter: memory-mapped down-counting timer, one-shot IRQ or periodic pulse.
// Optional prescaler at offset 3 when TC_PRESCALE_EN is defined.  Rev 1.0
// -----------------------------------------------------------------------------
module timer_counter #(
  parameter logic [31:0] PRESET_RST = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           reset,
  timer_counter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] MODE_RELOAD = 2'b01;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_ctrl, w_ctrl_nxt;
  logic [31:0] r_preset, w_preset_nxt;
  logic [31:0] r_count, w_count_nxt;
  logic        r_irq_flag, w_irq_flag_nxt;
  logic        w_ctrl_wr;
  logic        w_tick;

`ifdef TC_PRESCALE_EN
  localparam logic [1:0] ADDR_PRESCALE = 2'd3;
  logic [15:0] r_prescale, w_prescale_nxt;
  logic [15:0] r_presc_cnt, w_presc_cnt_nxt;
  assign w_tick = (r_presc_cnt == r_prescale);
`else
  assign w_tick = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_ctrl     <= 4'd0;
      r_preset   <= PRESET_RST;
      r_count    <= 32'd0;
      r_irq_flag <= 1'b0;
`ifdef TC_PRESCALE_EN
      r_prescale  <= 16'd0;
      r_presc_cnt <= 16'd0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_ctrl     <= w_ctrl_nxt;
      r_preset   <= w_preset_nxt;
      r_count    <= w_count_nxt;
      r_irq_flag <= w_irq_flag_nxt;
`ifdef TC_PRESCALE_EN
      r_prescale  <= w_prescale_nxt;
      r_presc_cnt <= w_presc_cnt_nxt;
`endif
    end
  end

  always_comb begin
    w_ctrl_wr      = bus.WE && (bus.addr == ADDR_CTRL);
    w_state_nxt    = r_state;
    w_ctrl_nxt     = r_ctrl;
    w_count_nxt    = r_count;
    w_irq_flag_nxt = r_irq_flag;
    w_preset_nxt   = (bus.WE && (bus.addr == ADDR_PRESET)) ? bus.Din : r_preset;
`ifdef TC_PRESCALE_EN
    w_prescale_nxt  = (bus.WE && (bus.addr == ADDR_PRESCALE)) ? bus.Din[15:0] : r_prescale;
    w_presc_cnt_nxt = r_presc_cnt;
`endif

    case (r_state)
      IDLE: begin
        if (r_ctrl[0]) w_state_nxt = LOAD;
      end
      LOAD: begin
        if (r_ctrl[0]) begin
          w_count_nxt = r_preset;
          w_state_nxt = CNT;
`ifdef TC_PRESCALE_EN
          w_presc_cnt_nxt = 16'd0;
`endif
        end else begin
          w_state_nxt = IDLE;
        end
      end
      CNT: begin
        if (!r_ctrl[0]) begin
          w_state_nxt = IDLE;
        end else if (w_tick) begin
`ifdef TC_PRESCALE_EN
          w_presc_cnt_nxt = 16'd0;
`endif
          if (r_count > 32'd1) begin
            w_count_nxt = r_count - 32'd1;
          end else begin
            // COUNT==1 and COUNT==0 (PRESET=0) both expire here; never wraps below 0
            w_count_nxt    = 32'd0;
            w_irq_flag_nxt = 1'b1;
            w_state_nxt    = INT;
          end
        end else begin
`ifdef TC_PRESCALE_EN
          w_presc_cnt_nxt = r_presc_cnt + 16'd1;
`endif
        end
      end
      INT: begin
        if (r_ctrl[2:1] == MODE_RELOAD) begin
          w_irq_flag_nxt = 1'b0;
          w_state_nxt    = LOAD;
        end else begin
          w_ctrl_nxt[0] = 1'b0;
          w_state_nxt   = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // A CPU CTRL write overrides the FSM's enable clear and always clears the flag
    if (w_ctrl_wr) begin
      w_ctrl_nxt     = bus.Din[3:0];
      w_irq_flag_nxt = 1'b0;
    end
  end

  always_comb begin
    bus.Dout = 32'd0;
    case (bus.addr)
      ADDR_CTRL:   bus.Dout = {28'd0, r_ctrl};
      ADDR_PRESET: bus.Dout = r_preset;
      ADDR_COUNT:  bus.Dout = r_count;
      default: begin
`ifdef TC_PRESCALE_EN
        bus.Dout = {16'd0, r_prescale};
`else
        bus.Dout = 32'd0;
`endif
      end
    endcase
  end

  assign bus.IRQ = r_irq_flag & r_ctrl[3];

endmodule
`default_nettype wire

// File: tb/tb_timer_counter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_timer_counter: directed table, hand-written corner sequences and random traffic vs a reference model.
// Rev 1.0
// -----------------------------------------------------------------------------
module tb_timer_counter;
  localparam logic [31:0] PRESET_RST = 32'hA5A5_0001;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  timer_counter_if bus ();

  timer_counter #(.PRESET_RST(PRESET_RST)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: register file plus a few "what happens next" flags
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset, m_count;
  logic        m_flag;
  logic [15:0] m_prescale;
  int          m_div;
  bit          m_loading, m_counting, m_expired;

  typedef struct {
    bit          we;
    logic [1:0]  addr;
    logic [31:0] din;
    logic [31:0] dout;
    bit          irq;
  } vec_t;

  vec_t tbl[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_ctrl = 4'd0; m_preset = PRESET_RST; m_count = 32'd0; m_flag = 1'b0;
    m_prescale = 16'd0; m_div = 0;
    m_loading = 0; m_counting = 0; m_expired = 0;
  endfunction

  function automatic void model_edge(bit rst, bit we, logic [1:0] a, logic [31:0] d);
    logic [3:0] ctrl_after;
    if (rst) begin
      model_reset();
      return;
    end
    ctrl_after = m_ctrl;
    if (m_expired) begin
      m_expired = 0;
      if (m_ctrl[2:1] == 2'b01) begin
        m_flag = 1'b0;
        m_loading = 1;
      end else begin
        ctrl_after[0] = 1'b0;
      end
    end else if (m_counting) begin
      if (!m_ctrl[0]) begin
        m_counting = 0;
      end else if (m_div != int'(m_prescale)) begin
        m_div = (m_div + 1) % 65536;
      end else begin
        m_div = 0;
        if (m_count > 1) m_count = m_count - 1;
        else begin
          m_count = 0; m_flag = 1'b1; m_counting = 0; m_expired = 1;
        end
      end
    end else if (m_loading) begin
      m_loading = 0;
      if (m_ctrl[0]) begin
        m_count = m_preset; m_div = 0; m_counting = 1;
      end
    end else if (m_ctrl[0]) begin
      m_loading = 1;
    end
    if (we) begin
      case (a)
        2'd0: begin ctrl_after = d[3:0]; m_flag = 1'b0; end
        2'd1: m_preset = d;
`ifdef TC_PRESCALE_EN
        2'd3: m_prescale = d[15:0];
`endif
        default: ;
      endcase
    end
    m_ctrl = ctrl_after;
  endfunction

  function automatic logic [31:0] model_read(logic [1:0] a);
    case (a)
      2'd0: return {28'd0, m_ctrl};
      2'd1: return m_preset;
      2'd2: return m_count;
      default: return {16'd0, m_prescale};
    endcase
  endfunction

  task automatic cycle(input bit rst, input bit we, input logic [1:0] a, input logic [31:0] d);
    reset    = rst;
    bus.WE   = we;
    bus.addr = a;
    bus.Din  = d;
    @(posedge clk);
    model_edge(rst, we, a, d);
    #1;
    check("dout_model", bus.Dout, model_read(a));
    check("irq_model", {31'd0, bus.IRQ}, {31'd0, m_flag & m_ctrl[3]});
  endtask

  task automatic idle_read(input logic [1:0] a);
    cycle(1'b0, 1'b0, a, 32'd0);
  endtask

  initial begin
    model_reset();
    // One-shot sequence: PRESET=3, CTRL=1001 written at row 5 (edge t)
    tbl[0]  = '{1'b0, 2'd0, 32'd0, 32'd0,      1'b0};
    tbl[1]  = '{1'b0, 2'd1, 32'd0, PRESET_RST, 1'b0};
    tbl[2]  = '{1'b0, 2'd2, 32'd0, 32'd0,      1'b0};
    tbl[3]  = '{1'b0, 2'd3, 32'd0, 32'd0,      1'b0};
    tbl[4]  = '{1'b1, 2'd1, 32'd3, 32'd3,      1'b0};
    tbl[5]  = '{1'b1, 2'd0, 32'h9, 32'h9,      1'b0};
    tbl[6]  = '{1'b0, 2'd2, 32'd0, 32'd0,      1'b0};
    tbl[7]  = '{1'b0, 2'd2, 32'd0, 32'd3,      1'b0};
    tbl[8]  = '{1'b0, 2'd2, 32'd0, 32'd2,      1'b0};
    tbl[9]  = '{1'b0, 2'd2, 32'd0, 32'd1,      1'b0};
    tbl[10] = '{1'b0, 2'd2, 32'd0, 32'd0,      1'b1};
    tbl[11] = '{1'b0, 2'd0, 32'd0, 32'h8,      1'b1};
    tbl[12] = '{1'b0, 2'd0, 32'd0, 32'h8,      1'b1};
    tbl[13] = '{1'b1, 2'd0, 32'h8, 32'h8,      1'b0};
    tbl[14] = '{1'b0, 2'd2, 32'd0, 32'd0,      1'b0};

    cycle(1'b1, 1'b0, 2'd0, 32'd0);
    cycle(1'b1, 1'b0, 2'd0, 32'd0);
    for (int i = 0; i < 15; i++) begin
      cycle(1'b0, tbl[i].we, tbl[i].addr, tbl[i].din);
      check($sformatf("tbl_dout[%0d]", i), bus.Dout, tbl[i].dout);
      check($sformatf("tbl_irq[%0d]", i), {31'd0, bus.IRQ}, {31'd0, tbl[i].irq});
    end

    // Auto-reload: one-cycle pulses every PRESET+2 = 4 cycles
    cycle(1'b0, 1'b1, 2'd1, 32'd2);
    cycle(1'b0, 1'b1, 2'd0, 32'hB);
    for (int k = 1; k <= 14; k++) begin
      idle_read(2'd2);
      check($sformatf("reload_irq[%0d]", k), {31'd0, bus.IRQ}, {31'd0, (k >= 4) && (k % 4 == 0)});
      if (k >= 2 && k % 4 == 2) check($sformatf("reload_cnt[%0d]", k), bus.Dout, 32'd2);
    end
    cycle(1'b0, 1'b1, 2'd0, 32'h0);
    for (int k = 0; k < 4; k++) idle_read(2'd2);

    // Same with IM=0: counting identical, IRQ held low
    cycle(1'b0, 1'b1, 2'd0, 32'h3);
    for (int k = 1; k <= 14; k++) begin
      idle_read(2'd2);
      check($sformatf("masked_irq[%0d]", k), {31'd0, bus.IRQ}, 32'd0);
    end
    cycle(1'b0, 1'b1, 2'd0, 32'h0);
    for (int k = 0; k < 4; k++) idle_read(2'd2);

    // PRESET=0: flag sets three edges after the enable write
    cycle(1'b0, 1'b1, 2'd1, 32'd0);
    cycle(1'b0, 1'b1, 2'd0, 32'h9);
    for (int k = 1; k <= 4; k++) begin
      idle_read(2'd2);
      check($sformatf("zero_irq[%0d]", k), {31'd0, bus.IRQ}, {31'd0, k >= 3});
    end
    cycle(1'b0, 1'b1, 2'd0, 32'h0);
    idle_read(2'd0);

    // Mid-count disable, COUNT write ignored, re-enable reloads, reset mid-count
    cycle(1'b0, 1'b1, 2'd1, 32'd10);
    cycle(1'b0, 1'b1, 2'd0, 32'h1);
    for (int k = 1; k <= 6; k++) begin
      idle_read(2'd2);
      if (k == 2) check("mid_load", bus.Dout, 32'd10);
    end
    cycle(1'b0, 1'b1, 2'd0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      idle_read(2'd2);
      check("mid_hold", bus.Dout, 32'd5);
    end
    cycle(1'b0, 1'b1, 2'd2, 32'h1234);
    check("count_ro", bus.Dout, 32'd5);
    cycle(1'b0, 1'b1, 2'd0, 32'h1);
    idle_read(2'd2);
    idle_read(2'd2);
    check("reenable_reload", bus.Dout, 32'd10);
    idle_read(2'd2);
    cycle(1'b1, 1'b0, 2'd2, 32'd0);
    check("rst_count", bus.Dout, 32'd0);
    idle_read(2'd0);
    check("rst_ctrl", bus.Dout, 32'd0);
    idle_read(2'd1);
    check("rst_preset", bus.Dout, PRESET_RST);

`ifdef TC_PRESCALE_EN
    // PRESCALE=2, PRESET=2: COUNT steps every 3 cycles, flag at edge t+8
    cycle(1'b0, 1'b1, 2'd3, 32'd2);
    cycle(1'b0, 1'b1, 2'd1, 32'd2);
    cycle(1'b0, 1'b1, 2'd0, 32'h9);
    for (int k = 1; k <= 8; k++) begin
      idle_read(2'd2);
      if (k == 2) check("psc_load", bus.Dout, 32'd2);
      if (k == 5) check("psc_step1", bus.Dout, 32'd1);
      check($sformatf("psc_irq[%0d]", k), {31'd0, bus.IRQ}, {31'd0, k == 8});
    end
    cycle(1'b0, 1'b1, 2'd3, 32'd0);
    cycle(1'b0, 1'b1, 2'd0, 32'h0);
`endif

    // Random bus traffic against the model
    for (int n = 0; n < 800; n++) begin
      bit          r_rst, r_we;
      logic [1:0]  r_a;
      logic [31:0] r_d;
      r_rst = ($urandom_range(0, 299) == 0);
      r_we  = ($urandom_range(0, 5) == 0);
      r_a   = 2'($urandom_range(0, 3));
      case (r_a)
        2'd1:    r_d = $urandom_range(0, 5);
        2'd3:    r_d = $urandom_range(0, 2);
        default: r_d = $urandom;
      endcase
      cycle(r_rst, r_we, r_a, r_d);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/timer_counter.md
Name: timer_counter

Overview:
- Memory-mapped programmable down-counting timer on the processor's peripheral bus (PrAddr/PrWD/PrWe side).
- The system bridge decodes the timer's address window and drives this block's addr/WE/Din. The bridge returns Dout to the CPU's PrRD.
- IRQ feeds one bit of the CPU's HWInt[5:0].
- Supports two modes: one-shot interrupt and periodic auto-reload pulse.

Parameters:
- PRESET_RST, 32'h0000_0000, reset value of the PRESET register

Ports:
- clk    input   1   system clock; all state updates on rising edge
- reset  input   1   synchronous reset, active-high
- addr   input   2   word offset within timer window (PrAddr[3:2])
- WE     input   1   write strobe, already qualified by bridge decode
- Din    input   32  write data (PrWD)
- Dout   output  32  read data, combinational from addr
- IRQ    output  1   interrupt request to CPU HWInt bit

Behaviour:
- Clock and reset: single clock clk. reset is synchronous and active-high.
- Register map (word offsets):
  - 0 CTRL: bit0 Enable, bits2:1 Mode, bit3 IM (interrupt mask). Bits 31:4 are ignored on write and read 0.
  - 1 PRESET: read/write.
  - 2 COUNT: read-only; writes ignored.
  - 3 reserved: reads 0, writes ignored.
- Dout is pure combinational decode of addr. There is no read side effect.
- Mode encoding: 00 = one-shot; 01 = auto-reload; 10/11 behave exactly as 00.
- Reset values: CTRL=0, PRESET=PRESET_RST, COUNT=0, irq_flag=0, state=IDLE, IRQ=0.
- IRQ = irq_flag & CTRL.IM, combinational from registers.
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: COUNT holds. If CTRL.Enable=1, go to LOAD.
  - LOAD: COUNT<=PRESET, go to CNT.
  - CNT: if Enable=0, go to IDLE with COUNT held. Else if COUNT>1, COUNT<=COUNT-1. Else if COUNT==1, COUNT<=0, irq_flag<=1, go to INT. Else (COUNT==0, i.e. PRESET=0), irq_flag<=1, go to INT.
  - INT, Mode 00: CTRL.Enable<=0, go to IDLE. irq_flag stays 1.
  - INT, Mode 01: irq_flag<=0, go to LOAD. IRQ is therefore high exactly one cycle.
- irq_flag clear in mode 00: any CPU write to CTRL clears irq_flag, or reset.
- Latency: a write of Enable=1 at edge t gives COUNT=PRESET at edge t+2. irq_flag sets at edge t+2+PRESET (PRESET>=1). Periodic period in mode 01 = PRESET+2 cycles.
- Simultaneous events:
  - A CPU CTRL write wins over the FSM's Enable clear in INT.
  - A CPU PRESET write during CNT does not affect COUNT until the next LOAD.
  - A CTRL write with Enable=0 during CNT/LOAD causes IDLE next edge.
- Wrap-around: COUNT never decrements below 0.
- Reset mid-count: returns to the reset values above on the next edge.

Optional Feature:
- Macro TC_PRESCALE_EN.
- Defined:
  - Offset 3 becomes PRESCALE[15:0], read/write, reset 0, upper bits read 0.
  - An internal prescaler counter clears in LOAD.
  - In CNT, the COUNT update/transition fires only when the prescaler equals PRESCALE; the prescaler then clears, otherwise it increments.
  - COUNT therefore steps every PRESCALE+1 cycles.
  - PRESCALE=0 gives identical behaviour to the macro-undefined build.
- Undefined: offset 3 is reserved as above.

Test Plan:
- Reset, then read offsets 0/1/2/3 -> Dout = 0, PRESET_RST, 0, 0; IRQ=0.
- PRESET=3, write CTRL=4'b1001 (IM, mode 00, enable) at edge t -> COUNT 3,2,1,0 at edges t+2..t+5; IRQ rises after t+5 and stays high; CTRL reads 4'b1000 after t+6; IRQ drops after the next CTRL write.
- PRESET=2, CTRL=4'b1011 (mode 01) -> IRQ one-cycle pulses exactly every 4 cycles, repeating ≥3 times; COUNT reloads to 2 each period.
- Same as the previous case with IM=0 -> IRQ stays 0 while COUNT sequencing is identical; PRESET=0 -> irq_flag sets at edge t+3.
- Mid-count, write CTRL Enable=0 at COUNT=5 -> COUNT holds 5; re-enable -> reloads PRESET (not 5); write COUNT offset -> no change; assert reset mid-count -> all registers and IRQ are 0 next edge.
- With TC_PRESCALE_EN, PRESCALE=2, PRESET=2, mode 00 -> COUNT steps every 3 cycles; irq_flag sets 2+3*2=8 edges after the enable write.
